// File: rtl/specfprnd_pipe.sv
// rtl/specfprnd_pipe.sv - two-stage special-case select, IEEE flag and result packing pipeline
module specfprnd_pipe #(
    parameter int EW  = 11,
    parameter int FW  = 52,
    parameter int SEW = 8,
    parameter int SFW = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              s,
    input  logic [EW-1:0]     eout,
    input  logic [FW-1:0]     fout,
    input  logic [FW:0]       nan,
    input  logic              ZERO,
    input  logic              NAN,
    input  logic              INF,
    input  logic              INV,
    input  logic              OVF,
    input  logic              TINY,
    input  logic              DBZ,
    input  logic              siginx,
    input  logic              OVFen,
    input  logic              UNFen,
    input  logic              db,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+FW:0]    fp_out,
    output logic [4:0]        IEEEp,
    input  logic              flag_clr,
    input  logic [4:0]        trap_en,
    output logic [4:0]        flags_sticky,
    output logic              trap
);
    localparam int W  = 1 + EW + FW;
    localparam int HW = 1 + SEW + SFW;

    generate
        if ((2 * HW != W) || (SEW > EW) || (SFW > FW)) begin : g_param_check
            $error("specfprnd_pipe: inconsistent wide/narrow format parameters");
        end
    endgenerate

    logic          s1_valid, s2_valid;
    logic          adv1, adv2;
    logic          s1_sign, s1_db;
    logic [EW-1:0] s1_exp;
    logic [FW-1:0] s1_frac;
    logic [4:0]    s1_flags;

    logic          sel_sign;
    logic [EW-1:0] sel_exp;
    logic [FW-1:0] sel_frac;
    logic [4:0]    sel_flags;
    logic          sp, ovf_m;
    logic [HW-1:0] half;
    logic [W-1:0]  packed_res;

    assign adv2      = ~s2_valid | out_ready;
    assign adv1      = ~s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;
    assign trap      = s2_valid & |(IEEEp & trap_en);

    // NaN beats INF beats ZERO; flags derive from the raw conditions, not the selected result
    always_comb begin
        sel_sign = s;
        sel_exp  = eout;
        sel_frac = fout;
        if (NAN) begin
            sel_sign = nan[FW];
            sel_exp  = '1;
            sel_frac = nan[FW-1:0];
        end else if (INF) begin
            sel_exp  = '1;
            sel_frac = '0;
        end else if (ZERO) begin
            sel_exp  = '0;
            sel_frac = '0;
        end
        sp           = NAN | INF | ZERO;
        ovf_m        = OVF & ~sp;
        sel_flags    = '0;
        sel_flags[0] = INV;
        sel_flags[1] = DBZ;
        sel_flags[2] = ovf_m;
        sel_flags[3] = TINY & ~sp & (UNFen | siginx);
        sel_flags[4] = (siginx | (ovf_m & ~OVFen)) & ~NAN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_db    <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_flags <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= sel_sign;
                s1_db    <= db;
                s1_exp   <= sel_exp;
                s1_frac  <= sel_frac;
                s1_flags <= sel_flags;
            end
        end
    end

    always_comb begin
        half       = {s1_sign, s1_exp[SEW-1:0], s1_frac[FW-1 -: SFW]};
        packed_res = s1_db ? {s1_sign, s1_exp, s1_frac} : {half, half};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            fp_out   <= '0;
            IEEEp    <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                fp_out <= packed_res;
                IEEEp  <= s1_flags;
            end
        end
    end

    // clear wins over history, but the flags of a beat retiring this cycle survive it
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_sticky <= '0;
        end else if (flag_clr) begin
            flags_sticky <= (s2_valid & out_ready) ? IEEEp : 5'b0;
        end else if (s2_valid & out_ready) begin
            flags_sticky <= flags_sticky | IEEEp;
        end
    end
endmodule
